// File: rtl/bcd_updown_counter_rpt.sv
// bcd_updown_counter_rpt: mod-(MAX_VAL+1) up/down set counter with hold-to-repeat, load, wrap pulse and BCD digits.
// Optional macro REPEAT_ACCEL_EN: repeat period drops to RATE_CYC/4 after ACCEL_AFTER repeat steps.
module bcd_updown_counter_rpt #(
    parameter int MAX_VAL     = 59,
    parameter int DELAY_CYC   = 50_000_000,
    parameter int RATE_CYC    = 25_000_000,
    parameter int ACCEL_AFTER = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_count,
    input  logic       enUP,
    input  logic       enDOWN,
    input  logic       load,
    input  logic [6:0] load_val,
    output logic [6:0] count,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       wrap
);
    localparam int TW = $clog2((DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC);
    localparam logic [TW-1:0] DLY_END = TW'(DELAY_CYC - 1);
    localparam logic [TW-1:0] RATE_END = TW'(RATE_CYC - 1);
    localparam logic [6:0] MAX = 7'(MAX_VAL);

    if (MAX_VAL < 1 || MAX_VAL > 99 || RATE_CYC < 4 || DELAY_CYC < 1 || ACCEL_AFTER < 0) begin : g_bad_params
        $error("bcd_updown_counter_rpt: illegal parameters");
    end

    typedef enum logic [1:0] {IDLE, WAIT, REP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          dir_q, dir_d;
    logic [6:0]    count_q, count_d;
    logic [3:0]    digit1_q, digit1_d, digit0_q, digit0_d;
    logic          wrap_q, wrap_d;
    logic          dir_up, dir_dn, held, dly_done, rep_done, step, step_up;
    logic [TW-1:0] per_end;

    assign dir_up   = en_count & enUP & ~enDOWN;
    assign dir_dn   = en_count & enDOWN & ~enUP;
    assign held     = dir_q ? dir_up : dir_dn;
    assign dly_done = timer_q == DLY_END;
    assign rep_done = timer_q == per_end;

`ifdef REPEAT_ACCEL_EN
    localparam int CW = $clog2(ACCEL_AFTER + 2);
    localparam logic [TW-1:0] FAST_END = TW'(RATE_CYC / 4 - 1);
    logic [CW-1:0] rep_cnt_q, rep_cnt_d;
    logic          accel;
    assign accel   = rep_cnt_q == CW'(ACCEL_AFTER);
    assign per_end = accel ? FAST_END : RATE_END;
    // Counts repeat steps taken in REP, saturating once the fast rate is reached.
    always_comb begin
        rep_cnt_d = (state_q == REP && held) ? rep_cnt_q + CW'(step && !accel) : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rep_cnt_q <= '0;
        else       rep_cnt_q <= rep_cnt_d;
    end
`else
    assign per_end = RATE_END;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            dir_q    <= 1'b0;
            count_q  <= '0;
            digit1_q <= '0;
            digit0_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            dir_q    <= dir_d;
            count_q  <= count_d;
            digit1_q <= digit1_d;
            digit0_q <= digit0_d;
            wrap_q   <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: if (dir_up || dir_dn) begin
                state_d = WAIT;
                dir_d   = dir_up;
                timer_d = '0;
            end
            WAIT: begin
                state_d = !held ? IDLE : dly_done ? REP : WAIT;
                timer_d = (!held || dly_done) ? '0 : timer_q + 1'b1;
            end
            REP: begin
                state_d = held ? REP : IDLE;
                timer_d = (!held || rep_done) ? '0 : timer_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Load wins over a step; digits are converted from the next count so they never lag it.
    always_comb begin
        step    = state_q == IDLE ? (dir_up | dir_dn)
                : held & (state_q == WAIT ? dly_done : state_q == REP && rep_done);
        step_up = state_q == IDLE ? dir_up : dir_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_val > MAX ? MAX : load_val;
        end else if (step && step_up) begin
            count_d = count_q >= MAX ? '0 : count_q + 1'b1;
            wrap_d  = count_q == MAX;
        end else if (step) begin
            count_d = (count_q == '0 || count_q > MAX) ? MAX : count_q - 1'b1;
            wrap_d  = count_q == '0;
        end
        digit1_d = 4'(count_d / 7'd10);
        digit0_d = 4'(count_d % 7'd10);
    end

    assign count  = count_q;
    assign digit1 = digit1_q;
    assign digit0 = digit0_q;
    assign wrap   = wrap_q;
endmodule
